// File: rtl/lvds_input_pkg.sv
// rtl/lvds_input_pkg.sv - shared types and constants for the LVDS input delay calibration
package lvds_input_pkg;

    localparam int               TAP_W           = 5;
    localparam logic [TAP_W-1:0] MAX_TAP         = 5'd31;
    localparam logic [3:0]       PATTERN_DEFAULT = 4'b1010;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_EVAL,
        S_CENTER,
        S_NEXT,
        S_DONE
    } calib_state_t;

endpackage

// File: rtl/lvds_calib_window.sv
// rtl/lvds_calib_window.sv - tracks the widest run of passing taps and its centre
module lvds_calib_window
    import lvds_input_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             tap_valid,
    input  logic             tap_pass,
    input  logic             sweep_end,
    input  logic [TAP_W-1:0] tap,
    output logic [5:0]       best_start,
    output logic [5:0]       best_len,
    output logic [TAP_W-1:0] centre
);
    logic [5:0] cur_start_q, cur_start_d;
    logic [5:0] cur_len_q, cur_len_d;
    logic [5:0] best_start_q, best_start_d;
    logic [5:0] best_len_q, best_len_d;
    logic [5:0] run_start;
    logic [5:0] run_len;
    logic [5:0] half_len;

    always_comb begin
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        run_start    = cur_start_q;
        run_len      = cur_len_q;
        if (tap_pass) begin
            if (cur_len_q == 6'd0) begin
                run_start = {1'b0, tap};
            end
            run_len = cur_len_q + 6'd1;
        end
        if (clear) begin
            cur_start_d  = '0;
            cur_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end else if (tap_valid) begin
            cur_start_d = run_start;
            cur_len_d   = run_len;
            // A failing tap or the last tap closes the run; strict > keeps the earliest of equal runs.
            if (!tap_pass || sweep_end) begin
                if (run_len > best_len_q) begin
                    best_start_d = run_start;
                    best_len_d   = run_len;
                end
                cur_len_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    assign half_len   = (best_len_q - 6'd1) >> 1;
    assign centre     = best_start_q[TAP_W-1:0] + half_len[TAP_W-1:0];
    assign best_start = best_start_q;
    assign best_len   = best_len_q;

endmodule

// File: rtl/lvds_idelay_calib.sv
// rtl/lvds_idelay_calib.sv - per-lane IDELAY tap sweep and centring against a training word
module lvds_idelay_calib
    import lvds_input_pkg::*;
#(
    parameter int                NLANES      = 4,
    parameter int                WORD_W      = 4,
    parameter logic [WORD_W-1:0] PATTERN     = WORD_W'(PATTERN_DEFAULT),
    parameter int                SETTLE      = 8,
    parameter int                WINDOW      = 64,
    parameter logic [TAP_W-1:0]  DEFAULT_TAP = 5'd0
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     idelay_rdy,
    input  logic                     sample_valid,
    input  logic [NLANES*WORD_W-1:0] lane_data,
    output logic [TAP_W-1:0]         cntvaluein,
    output logic [NLANES-1:0]        ld,
    output logic                     busy,
    output logic                     done,
    output logic [NLANES-1:0]        fail_mask,
    output logic [NLANES*TAP_W-1:0]  tap_out
);
    localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int SCNT_W = $clog2(SETTLE + 1);
    localparam int MCNT_W = $clog2(WINDOW + 1);

    calib_state_t            state_q, state_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [TAP_W-1:0]        tap_q, tap_d;
    logic [SCNT_W-1:0]       settle_q, settle_d;
    logic [MCNT_W-1:0]       match_q, match_d;
    logic                    pass_q, pass_d;
    logic [TAP_W-1:0]        cntvaluein_q, cntvaluein_d;
    logic [NLANES-1:0]       ld_q, ld_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [NLANES-1:0]       fail_mask_q, fail_mask_d;
    logic [NLANES*TAP_W-1:0] tap_out_q, tap_out_d;

    logic              win_clear, win_valid, win_end;
    logic [5:0]        win_best_start, win_best_len;
    logic [TAP_W-1:0]  win_centre;
    logic [TAP_W-1:0]  final_tap;
    logic [WORD_W-1:0] lane_word;
    logic              rdy_lost;

    lvds_calib_window u_window (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (win_clear),
        .tap_valid  (win_valid),
        .tap_pass   (pass_q),
        .sweep_end  (win_end),
        .tap        (tap_q),
        .best_start (win_best_start),
        .best_len   (win_best_len),
        .centre     (win_centre)
    );

    assign lane_word = lane_data[int'(lane_q)*WORD_W +: WORD_W];
    assign rdy_lost  = !idelay_rdy && (state_q inside {S_LOAD, S_SETTLE, S_CHECK, S_EVAL});
    // An empty window has best_start == 0, so the same test also covers an unused start.
    assign final_tap = (win_best_len == 6'd0 && win_best_start == 6'd0) ? DEFAULT_TAP : win_centre;

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        tap_d        = tap_q;
        settle_d     = settle_q;
        match_d      = match_q;
        pass_d       = pass_q;
        cntvaluein_d = cntvaluein_q;
        ld_d         = '0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        fail_mask_d  = fail_mask_q;
        tap_out_d    = tap_out_q;
        win_clear    = 1'b0;
        win_valid    = 1'b0;
        win_end      = 1'b0;
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end else if (rdy_lost) begin
            // Partial sweep is untrustworthy once the delay line lost calibration.
            win_clear = 1'b1;
            tap_d     = '0;
            state_d   = S_WAIT_RDY;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d     = S_WAIT_RDY;
                        busy_d      = 1'b1;
                        fail_mask_d = '0;
                        lane_d      = '0;
                        tap_d       = '0;
                        win_clear   = 1'b1;
                    end
                end
                S_WAIT_RDY: begin
                    if (idelay_rdy) state_d = S_LOAD;
                end
                S_LOAD: begin
                    cntvaluein_d = tap_q;
                    ld_d[lane_q] = 1'b1;
                    settle_d     = '0;
                    state_d      = S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q == SCNT_W'(SETTLE - 1)) begin
                        match_d = '0;
                        state_d = S_CHECK;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (sample_valid) begin
                        if (lane_word != PATTERN) begin
                            pass_d  = 1'b0;
                            state_d = S_EVAL;
                        end else if (match_q == MCNT_W'(WINDOW - 1)) begin
                            pass_d  = 1'b1;
                            state_d = S_EVAL;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    win_valid = 1'b1;
                    win_end   = (tap_q == MAX_TAP);
                    if (tap_q == MAX_TAP) begin
                        state_d = S_CENTER;
                    end else begin
                        tap_d   = tap_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
                S_CENTER: begin
                    if (win_best_len == 6'd0) fail_mask_d[lane_q] = 1'b1;
                    cntvaluein_d                                = final_tap;
                    ld_d[lane_q]                                = 1'b1;
                    tap_out_d[int'(lane_q)*TAP_W +: TAP_W]      = final_tap;
                    state_d                                     = S_NEXT;
                end
                S_NEXT: begin
                    if (lane_q == LANE_W'(NLANES - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        lane_d    = lane_q + 1'b1;
                        tap_d     = '0;
                        win_clear = 1'b1;
                        state_d   = S_WAIT_RDY;
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            lane_q       <= '0;
            tap_q        <= '0;
            settle_q     <= '0;
            match_q      <= '0;
            pass_q       <= 1'b0;
            cntvaluein_q <= '0;
            ld_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_mask_q  <= '0;
            tap_out_q    <= {NLANES{DEFAULT_TAP}};
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            tap_q        <= tap_d;
            settle_q     <= settle_d;
            match_q      <= match_d;
            pass_q       <= pass_d;
            cntvaluein_q <= cntvaluein_d;
            ld_q         <= ld_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_mask_q  <= fail_mask_d;
            tap_out_q    <= tap_out_d;
        end
    end

    assign cntvaluein = cntvaluein_q;
    assign ld         = ld_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fail_mask  = fail_mask_q;
    assign tap_out    = tap_out_q;

endmodule

// File: doc/lvds_idelay_calib.md
Name: lvds_idelay_calib

Overview:
Training-pattern controller for the ADC LVDS data lanes. For each lane in turn it sweeps the input IDELAYE2 tap (VAR_LOAD mode) from 0 to 31 and checks the captured lane word against a fixed training pattern at every tap. It then loads the centre of the widest passing tap window. It sits beside the data receiver in the ADC clock domain, is started from a CR register bit, and reports status and final taps to the AXI-lite read side.

Parameters:
NLANES, 4, number of LVDS data lanes calibrated
WORD_W, 4, bits per captured lane word
PATTERN, 4'b1010, expected training word on every lane
SETTLE, 8, clk cycles waited after a tap load before checking
WINDOW, 64, consecutive valid samples that must all match for a tap to pass
DEFAULT_TAP, 5'd0, tap loaded on a lane with no passing tap

Ports:
clk  in  1  ADC-domain clock
resetn  in  1  asynchronous active-low reset
start  in  1  single-cycle calibration request
abort  in  1  single-cycle abort request
idelay_rdy  in  1  IDELAYCTRL RDY, already synchronised to clk
sample_valid  in  1  lane_data holds a new word this cycle
lane_data  in  NLANES*WORD_W  captured words; lane i at [i*WORD_W +: WORD_W]
cntvaluein  out  5  tap value shared by all IDELAYE2s
ld  out  NLANES  one-hot load strobe per lane
busy  out  1  calibration in progress
done  out  1  one-cycle pulse when calibration ends, including an abort
fail_mask  out  NLANES  bit i set when lane i had no passing tap
tap_out  out  NLANES*5  final tap per lane

Behaviour:
- Reset values: cntvaluein=0, ld=0, busy=0, done=0, fail_mask=0, tap_out=all DEFAULT_TAP.
- States: IDLE, WAIT_RDY, LOAD, SETTLE, CHECK, EVAL, CENTER, NEXT, DONE.
- IDLE: on start go to WAIT_RDY and assert busy from the next cycle. Also clear fail_mask, lane=0, tap=0, and the run trackers (cur_start, cur_len, best_start, best_len, all 6-bit).
- WAIT_RDY: stay here until idelay_rdy=1, then go to LOAD.
- LOAD: drive cntvaluein=tap and ld[lane]=1 for exactly one cycle, then go to SETTLE.
- SETTLE: count SETTLE cycles, then go to CHECK with the match counter cleared.
- CHECK:
  - Counts only cycles with sample_valid=1.
  - On any mismatch of the lane word vs PATTERN, mark the tap failed and go to EVAL immediately.
  - After WINDOW matches, mark the tap passed and go to EVAL.
  - There is no timeout; sample_valid is guaranteed by the receiver.
- EVAL (1 cycle):
  - Pass: if cur_len==0 then cur_start=tap; cur_len++.
  - Fail: if cur_len>best_len then best=cur; then cur_len=0.
  - If tap<31: tap++ and go to LOAD.
  - If tap==31: close any open run with the same rule (a run ending at tap 31 is valid), then go to CENTER.
- Ties: the strictly-greater comparison keeps the earlier window.
- CENTER:
  - If best_len==0: set fail_mask[lane] and final=DEFAULT_TAP.
  - Otherwise final = best_start + (best_len-1)>>1 (floor).
  - Drive cntvaluein=final and ld[lane]=1 for one cycle, write tap_out[lane], then go to NEXT.
- NEXT: if lane==NLANES-1 go to DONE. Otherwise lane++, tap=0, trackers cleared, go to WAIT_RDY.
- DONE: pulse done for 1 cycle, deassert busy, return to IDLE.
- start while busy: ignored.
- abort (any state except IDLE): on the next cycle, ld=0, done pulses, busy=0, state=IDLE.
  - The lane in progress keeps its last loaded tap.
  - tap_out and fail_mask of lanes not yet finished are unchanged.
- start and abort in the same cycle from IDLE: abort wins and nothing starts.
- idelay_rdy falling in LOAD, SETTLE, CHECK or EVAL: discard the current lane's trackers, set tap=0, go to WAIT_RDY. Completed lanes are kept.
- ld is never asserted on more than one lane, and never two cycles in a row.
- Cycle count per tap: 1 + SETTLE + (cycles to WINDOW valid samples or first mismatch) + 1.

Decomposition:
- Package lvds_input_pkg holds:
  - the state enum typedef calib_state_t;
  - TAP_W=5 and MAX_TAP=31;
  - the default PATTERN constant.
- One sub-module, lvds_calib_window, holds the cur/best run trackers, the EVAL update, the end-of-sweep close, and the centre arithmetic. Its inputs are clear, tap_pass, tap_valid and sweep_end; its outputs are best_start, best_len and centre.
- The top holds the FSM and counters.

Test Plan:
- Lane 0 passes taps 8..20, others 10..14; start → ld pulses, tap_out lane0=14 and others=12, fail_mask=0, one done pulse, busy low after.
- Lane 1 passes 2..5 and 20..29 → tap_out[1]=24; lane 2 passes 3..6 and 10..13 (tie) → tap_out[2]=4.
- Lane 3 passes 25..31 → tap_out[3]=28; lane 0 never matches → fail_mask=4'b0001, tap_out[0]=0, final ld with cntvaluein=0.
- idelay_rdy dropped for 10 cycles during lane 2 tap 15 → lane 2 re-sweeps from tap 0; lanes 0 and 1 results unchanged; final results match the no-glitch run.
- abort during lane 1 CHECK → done pulse next cycle, busy=0, tap_out[1..3] unchanged; a second start while busy is ignored (trace shows a single sweep).
- Asynchronous resetn assertion mid-SETTLE → all outputs at reset values immediately; a single mismatch at sample 63 of 64 fails that tap.
